// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the SPI slave and the AXI-Stream SPI master.
//   SPI_MODE0..3       : {CPOL,CPHA} encodings
//   spi_state_t        : slave shift engine states
//   spi_sample_on_rise : 1 when data is sampled on the rising sclk edge
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // Modes 0 and 3 (CPOL == CPHA) sample on the rising edge, modes 1 and 2 on the falling edge.
    function automatic logic spi_sample_on_rise(input logic [1:0] mode);
        if (mode[1] == mode[0]) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (RESET_VALUE while in reset)
module spi_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_slave.sv
// SPI slave with AXI-Stream tx/rx interfaces, oversampling sclk/mosi/cs_n on clk.
//   s_axis_*          : word to transmit on miso (one-word holding register)
//   m_axis_*          : received mosi word, right-aligned
//   sclk, mosi, cs_n  : asynchronous SPI pins; miso_o/miso_t drive miso (miso_t=1 is high-Z)
//   enable            : ignore new chip-select sessions when low
//   lsb_first, spi_mode, spi_word_width : latched at the start of each session
//   rx_overrun_error  : sticky until the next m_axis handshake
//   tx_underrun_error : one-cycle pulse when a word loads from an empty holding register
//   bus_active        : shift engine in SHIFT
module spi_slave
    import spi_pkg::*;
#(
    parameter  int AXIS_DATA_WIDTH    = 8,
    localparam int WORD_COUNTER_WIDTH = $clog2(AXIS_DATA_WIDTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          cs_n,
    output logic                          miso_o,
    output logic                          miso_t,
    input  logic                          enable,
    input  logic                          lsb_first,
    input  logic [1:0]                    spi_mode,
    input  logic [WORD_COUNTER_WIDTH-1:0] spi_word_width,
    output logic                          rx_overrun_error,
    output logic                          tx_underrun_error,
    output logic                          bus_active
);

    localparam int DW  = AXIS_DATA_WIDTH;
    localparam int WCW = WORD_COUNTER_WIDTH;

    // Next bit to present: MSB-first words are kept left-aligned in the shift register.
    function automatic logic tx_head(input logic [DW-1:0] w, input logic lsb);
        if (lsb) begin
            return w[0];
        end else begin
            return w[DW-1];
        end
    endfunction

    function automatic logic [DW-1:0] tx_advance(input logic [DW-1:0] w, input logic lsb);
        if (lsb) begin
            return {1'b0, w[DW-1:1]};
        end else begin
            return {w[DW-2:0], 1'b0};
        end
    endfunction

    logic sclk_s, mosi_s, cs_n_s;
    logic sclk_prev_r, cs_n_prev_r;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s;
    logic sample_edge_s, shift_edge_s;

    spi_state_t state_r, state_next_s;
    logic start_s, stop_s, boundary_s, load_s;

    logic [1:0]     mode_r;
    logic           lsb_r;
    logic [WCW-1:0] width_r, bit_cnt_r, bit_cnt_inc_s;
    logic [DW-1:0]  rx_shift_r, rx_next_s;
    logic [DW-1:0]  tx_shift_r, load_word_s, load_aligned_s;
    logic           load_lsb_s;
    logic [WCW-1:0] load_width_s;

    logic [DW-1:0]  hold_r;
    logic           hold_valid_r, tx_ready_r, s_hs_s, m_hs_s;
    logic [DW-1:0]  m_tdata_r;
    logic           m_tvalid_r, overrun_r, underrun_r, miso_o_r, miso_t_r;

    spi_sync #(.RESET_VALUE(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.RESET_VALUE(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
    spi_sync #(.RESET_VALUE(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d(cs_n), .q(cs_n_s));

    // Previous synchronized sclk/cs_n for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_r <= 1'b0;
            cs_n_prev_r <= 1'b1;
        end else begin
            sclk_prev_r <= sclk_s;
            cs_n_prev_r <= cs_n_s;
        end
    end

    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign cs_fall_s   = cs_n_prev_r & ~cs_n_s;

    // Map sclk edges to sample/shift roles for the latched mode.
    always_comb begin
        sample_edge_s = 1'b0;
        shift_edge_s  = 1'b0;
        if (spi_sample_on_rise(mode_r)) begin
            sample_edge_s = sclk_rise_s;
            shift_edge_s  = sclk_fall_s;
        end else begin
            sample_edge_s = sclk_fall_s;
            shift_edge_s  = sclk_rise_s;
        end
    end

    assign bit_cnt_inc_s = bit_cnt_r + {{(WCW-1){1'b0}}, 1'b1};

    // Next-state logic and session/word control strobes.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        stop_s       = 1'b0;
        boundary_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable && cs_fall_s) begin
                    state_next_s = SHIFT;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cs_n_s) begin
                    state_next_s = IDLE;
                    stop_s       = 1'b1;
                end else if (sample_edge_s && (bit_cnt_inc_s == width_r)) begin
                    boundary_s   = 1'b1;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign load_s       = start_s | boundary_s;
    assign s_hs_s       = s_axis_tvalid & tx_ready_r;
    assign m_hs_s       = m_tvalid_r & m_axis_tready;
    // A session start uses the live configuration; later words use the latched copy.
    assign load_lsb_s   = start_s ? lsb_first : lsb_r;
    assign load_width_s = start_s ? spi_word_width : width_r;
    assign load_word_s  = hold_valid_r ? hold_r : {DW{1'b0}};
    assign load_aligned_s = load_lsb_s ? load_word_s
                                       : (load_word_s << (WCW'(DW) - load_width_s));

    // LSB-first bits land at their own index; MSB-first bits shift in from the bottom.
    assign rx_next_s = lsb_r ? (rx_shift_r | ({{(DW-1){1'b0}}, mosi_s} << bit_cnt_r))
                             : {rx_shift_r[DW-2:0], mosi_s};

    // TX holding register: filled by s_axis, emptied by a shift-register load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r       <= {DW{1'b0}};
            hold_valid_r <= 1'b0;
            tx_ready_r   <= 1'b1;
            underrun_r   <= 1'b0;
        end else begin
            underrun_r <= load_s & ~hold_valid_r;
            if (s_hs_s) begin
                hold_r       <= s_axis_tdata;
                hold_valid_r <= 1'b1;
                tx_ready_r   <= 1'b0;
            end else if (load_s) begin
                hold_valid_r <= 1'b0;
                tx_ready_r   <= 1'b1;
            end
        end
    end

    // Shift engine: configuration latch, bit counter, rx/tx shift registers and miso.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r     <= SPI_MODE0;
            lsb_r      <= 1'b0;
            width_r    <= WCW'(DW);
            bit_cnt_r  <= {WCW{1'b0}};
            rx_shift_r <= {DW{1'b0}};
            tx_shift_r <= {DW{1'b0}};
            miso_o_r   <= 1'b0;
            miso_t_r   <= 1'b1;
        end else if (start_s) begin
            mode_r     <= spi_mode;
            lsb_r      <= lsb_first;
            width_r    <= spi_word_width;
            bit_cnt_r  <= {WCW{1'b0}};
            rx_shift_r <= {DW{1'b0}};
            miso_t_r   <= 1'b0;
            // CPHA=0 needs bit0 on the wire before the first sclk edge.
            if (!spi_mode[0]) begin
                miso_o_r   <= tx_head(load_aligned_s, lsb_first);
                tx_shift_r <= tx_advance(load_aligned_s, lsb_first);
            end else begin
                tx_shift_r <= load_aligned_s;
            end
        end else if (stop_s) begin
            bit_cnt_r  <= {WCW{1'b0}};
            rx_shift_r <= {DW{1'b0}};
            miso_t_r   <= 1'b1;
        end else if (state_r == SHIFT) begin
            if (boundary_s) begin
                bit_cnt_r  <= {WCW{1'b0}};
                rx_shift_r <= {DW{1'b0}};
                tx_shift_r <= load_aligned_s;
            end else if (sample_edge_s) begin
                bit_cnt_r  <= bit_cnt_inc_s;
                rx_shift_r <= rx_next_s;
            end else if (shift_edge_s) begin
                miso_o_r   <= tx_head(tx_shift_r, lsb_r);
                tx_shift_r <= tx_advance(tx_shift_r, lsb_r);
            end
        end
    end

    // RX output register and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata_r  <= {DW{1'b0}};
            m_tvalid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (boundary_s) begin
            m_tdata_r  <= rx_next_s;
            m_tvalid_r <= 1'b1;
            if (m_tvalid_r && !m_axis_tready) begin
                overrun_r <= 1'b1;
            end else if (m_hs_s) begin
                overrun_r <= 1'b0;
            end
        end else if (m_hs_s) begin
            m_tvalid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end
    end

    assign s_axis_tready     = tx_ready_r;
    assign m_axis_tdata      = m_tdata_r;
    assign m_axis_tvalid     = m_tvalid_r;
    assign miso_o            = miso_o_r;
    assign miso_t            = miso_t_r;
    assign rx_overrun_error  = overrun_r;
    assign tx_underrun_error = underrun_r;
    assign bus_active        = (state_r == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready;
    logic       sclk, mosi, cs_n, miso_o, miso_t, enable, lsb_first;
    logic [1:0] spi_mode;
    logic [3:0] spi_word_width;
    logic       rx_overrun_error, tx_underrun_error, bus_active;

    spi_slave #(.AXIS_DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso_o(miso_o), .miso_t(miso_t),
        .enable(enable), .lsb_first(lsb_first), .spi_mode(spi_mode),
        .spi_word_width(spi_word_width), .rx_overrun_error(rx_overrun_error),
        .tx_underrun_error(tx_underrun_error), .bus_active(bus_active)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         underrun_cnt = 0;
    logic [7:0] exp_q[$];
    logic [1:0] cur_mode;
    logic       cur_lsb;
    int         cur_width;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count underrun pulses and compare every accepted rx word with the scoreboard.
    always @(negedge clk) begin
        if (tx_underrun_error === 1'b1) underrun_cnt++;
        if (rst === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got 0x%0h expected no word", m_axis_tdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("rx_word", {24'd0, m_axis_tdata}, {24'd0, e});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (s_axis_tready !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_ready_wait: got tready=0 expected tready=1 within 50 cycles");
        end
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        tick(1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic cs_start(input logic [1:0] mode, input logic lsb, input int width);
        cur_mode       = mode;
        cur_lsb        = lsb;
        cur_width      = width;
        spi_mode       = mode;
        lsb_first      = lsb;
        spi_word_width = 4'(width);
        sclk           = mode[1];
        tick(6);
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_stop();
        tick(6);
        cs_n = 1'b1;
        tick(10);
    endtask

    function automatic int bidx(input int i);
        return cur_lsb ? i : cur_width - 1 - i;
    endfunction

    // Master side of one word: drive mosi on the shift edge, sample miso on the sample edge.
    task automatic spi_word(input logic [7:0] mo, input int nb, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = cur_mode[1];
        cpha = cur_mode[0];
        mi   = 8'h00;
        if (!cpha) mosi = mo[bidx(0)];
        for (int i = 0; i < nb; i++) begin
            tick(6);
            sclk = ~cpol;
            if (!cpha) mi[bidx(i)] = miso_o;
            else       mosi = mo[bidx(i)];
            tick(6);
            sclk = cpol;
            if (!cpha) begin
                if (i < cur_width - 1) mosi = mo[bidx(i + 1)];
            end else begin
                mi[bidx(i)] = miso_o;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_tready"}, s_axis_tready, 1);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tdata"}, m_axis_tdata, 0);
        check({tag, "_miso_o"}, miso_o, 0);
        check({tag, "_miso_t"}, miso_t, 1);
        check({tag, "_overrun"}, rx_overrun_error, 0);
        check({tag, "_underrun"}, tx_underrun_error, 0);
        check({tag, "_bus_active"}, bus_active, 0);
    endtask

    initial begin
        logic [7:0] mi;
        int         u0;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        enable = 1'b1; spi_mode = 2'b00; lsb_first = 1'b0; spi_word_width = 4'd8;
        cur_mode = 2'b00; cur_lsb = 1'b0; cur_width = 8;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(3);

        // Mode 0, MSB-first, 8 bits.
        push_tx(8'hA5);
        u0 = underrun_cnt;
        cs_start(2'b00, 1'b0, 8);
        check("t1_miso_t_active", miso_t, 0);
        check("t1_bus_active", bus_active, 1);
        push_tx(8'h00);
        exp_q.push_back(8'h3C);
        spi_word(8'h3C, 8, mi);
        check("t1_master_rx", mi, 8'hA5);
        cs_stop();
        check("t1_overrun", rx_overrun_error, 0);
        check("t1_underrun_cnt", underrun_cnt - u0, 0);
        check("t1_miso_t_idle", miso_t, 1);
        check("t1_bus_idle", bus_active, 0);
        check("t1_q_empty", exp_q.size(), 0);

        // Mode 3, LSB-first, 8 bits.
        push_tx(8'h81);
        cs_start(2'b11, 1'b1, 8);
        push_tx(8'h00);
        exp_q.push_back(8'h0F);
        spi_word(8'h0F, 8, mi);
        check("t2_master_rx", mi, 8'h81);
        cs_stop();
        check("t2_q_empty", exp_q.size(), 0);

        // Mode 1, MSB-first, 5 bits.
        push_tx(8'h13);
        cs_start(2'b01, 1'b0, 5);
        push_tx(8'h00);
        exp_q.push_back(8'h1A);
        spi_word(8'h1A, 5, mi);
        check("t3_master_rx", mi, 8'h13);
        cs_stop();
        check("t3_q_empty", exp_q.size(), 0);

        // Two words under one chip select with the rx sink stalled: second word overwrites.
        m_axis_tready = 1'b0;
        push_tx(8'h11);
        cs_start(2'b00, 1'b0, 8);
        push_tx(8'h22);
        exp_q.push_back(8'hAA);
        spi_word(8'h55, 8, mi);
        check("t4_master_rx0", mi, 8'h11);
        check("t4_tvalid_w0", m_axis_tvalid, 1);
        check("t4_no_overrun_w0", rx_overrun_error, 0);
        push_tx(8'h00);
        spi_word(8'hAA, 8, mi);
        check("t4_master_rx1", mi, 8'h22);
        cs_stop();
        check("t4_overrun_set", rx_overrun_error, 1);
        check("t4_tdata_pending", m_axis_tdata, 8'hAA);
        tick(5);
        check("t4_overrun_sticky", rx_overrun_error, 1);
        m_axis_tready = 1'b1;
        tick(2);
        check("t4_overrun_cleared", rx_overrun_error, 0);
        check("t4_tvalid_cleared", m_axis_tvalid, 0);
        check("t4_q_empty", exp_q.size(), 0);

        // Abort after 3 bits, then a full word.
        push_tx(8'h5A);
        cs_start(2'b00, 1'b0, 8);
        spi_word(8'hF0, 3, mi);
        cs_stop();
        check("t5_miso_t_cs_high", miso_t, 1);
        check("t5_bus_idle", bus_active, 0);
        check("t5_no_tvalid", m_axis_tvalid, 0);
        push_tx(8'h96);
        cs_start(2'b00, 1'b0, 8);
        push_tx(8'h00);
        exp_q.push_back(8'hC3);
        spi_word(8'hC3, 8, mi);
        check("t5_master_rx", mi, 8'h96);
        cs_stop();
        check("t5_q_empty", exp_q.size(), 0);

        // Empty holding register at chip-select fall, then reset mid-word.
        m_axis_tready = 1'b0;
        check("t6_hold_empty", s_axis_tready, 1);
        u0 = underrun_cnt;
        cs_start(2'b00, 1'b0, 8);
        check("t6_underrun_pulses", underrun_cnt - u0, 1);
        check("t6_underrun_low", tx_underrun_error, 0);
        spi_word(8'h77, 8, mi);
        check("t6_master_rx_zero", mi, 8'h00);
        check("t6_tvalid_pending", m_axis_tvalid, 1);
        check("t6_tdata_pending", m_axis_tdata, 8'h77);
        push_tx(8'h42);
        check("t6_hold_full", s_axis_tready, 0);
        spi_word(8'hFF, 4, mi);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(2);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick(10);
        check("t6_no_tvalid_after_reset", m_axis_tvalid, 0);
        check("t6_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave (responder) for the SoC SPI subsystem. It is the counterpart of the existing AXI-Stream SPI master. It oversamples external sclk/mosi/cs_n on the system clock, shifts out a word taken from an AXIS input on miso, and delivers each received mosi word on an AXIS output. It supports all four SPI modes, MSB/LSB-first ordering, runtime word width, and back-to-back words under one chip select.

Parameters:
AXIS_DATA_WIDTH, 8, max SPI word width and AXIS tdata width
WORD_COUNTER_WIDTH, $clog2(AXIS_DATA_WIDTH)+1, derived (localparam), bit counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s_axis_tdata  in  AXIS_DATA_WIDTH  word to transmit on miso
s_axis_tvalid  in  1  tx word valid
s_axis_tready  out  1  tx holding register empty
m_axis_tdata  out  AXIS_DATA_WIDTH  received word, right-aligned
m_axis_tvalid  out  1  rx word valid
m_axis_tready  in  1  rx word accepted
sclk  in  1  SPI clock (asynchronous)
mosi  in  1  SPI data in (asynchronous)
cs_n  in  1  chip select, active low (asynchronous)
miso_o  out  1  SPI data out
miso_t  out  1  miso tristate, 1 = high-Z
enable  in  1  block enable; 0 ignores cs_n
lsb_first  in  1  bit order
spi_mode  in  2  {CPOL,CPHA}
spi_word_width  in  WORD_COUNTER_WIDTH  bits per word, 1..AXIS_DATA_WIDTH
rx_overrun_error  out  1  rx word lost
tx_underrun_error  out  1  word started with empty tx holding register
bus_active  out  1  chip select asserted and transfer in progress

Behaviour:
- Reset values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, miso_o=0, miso_t=1, both error flags 0, bus_active=0, state IDLE.
- sclk, mosi and cs_n each pass through a 2-flop synchronizer. Edges are detected on the synchronized sclk. Supported sclk is at most clk/8.
- Sample edge: rising for modes 0 and 3, falling for modes 1 and 2. Shift edge is the opposite edge.
- TX holding register:
  - s_axis_tready = !hold_valid.
  - A handshake loads the register.
  - A word load into the shift register clears it.
- State IDLE:
  - miso_t=1.
  - A synchronized cs_n fall with enable=1 latches spi_mode, lsb_first and spi_word_width, loads the tx word, clears the bit counter, sets miso_t=0 and goes to SHIFT.
- Tx load:
  - If the holding register is empty, zeros are shifted and tx_underrun_error pulses for 1 cycle.
  - For CPHA=0, bit0 of the word (MSB or LSB per lsb_first) is driven on miso_o in the cycle after the load. This must be within 4 clk of the cs_n pin fall.
- State SHIFT, sample edge: shift synchronized mosi into the rx register and increment the bit counter.
- State SHIFT, shift edge: present the next tx bit.
  - For CPHA=0, shift edges present bits 1..N-1.
  - For CPHA=1, shift edges present bits 0..N-1.
- Word boundary (bit counter reaches spi_word_width):
  - The rx word goes to m_axis_tdata, right-aligned with upper bits zero, and m_axis_tvalid is set.
  - The counter clears and the next tx word loads, giving continuous words while cs_n stays low.
  - For CPHA=0, the shift edge following the boundary presents bit0 of the new word.
  - m_axis_tvalid rises within 4 clk of the final sample edge at the pins.
- Overrun:
  - If m_axis_tvalid=1 and no handshake occurs in the boundary cycle, the new word overwrites, and rx_overrun_error sets.
  - rx_overrun_error is sticky until the next m_axis handshake.
  - A handshake and a boundary in the same cycle is not an overrun.
- cs_n deassert (synchronized), in any state:
  - Return to IDLE, miso_t=1, discard the partial rx word.
  - A partial tx word is lost; the holding register is unaffected.
- enable=0 during SHIFT: finish the current cs_n session and ignore new ones.
- bus_active = (state==SHIFT).
- Reset mid-transfer: immediate return to reset values, including the holding register and a pending m_axis word.

Decomposition:
- Shared package spi_pkg holds:
  - mode constants SPI_MODE0..3
  - state encoding (IDLE, SHIFT)
  - a function returning the sample edge select from {CPOL,CPHA}, shared with the master
- One sub-module, spi_sync: a 2-flop synchronizer with parameterized reset value. It is instantiated for sclk (reset value per CPOL idle is not needed; 0), mosi (0) and cs_n (1).

Test Plan:
- Mode 0, MSB-first, width 8, tx 0xA5, master sends 0x3C -> master receives 0xA5; m_axis_tdata=0x3C; tvalid=1; no errors.
- Mode 3, LSB-first, width 8, tx 0x81, rx 0x0F -> miso bit order 1,0,0,0,0,0,0,1; m_axis_tdata=0x0F.
- Mode 1, width 5, tx 0x13, rx 0x1A -> m_axis_tdata=0x1A with upper bits 0; master receives 0x13.
- Continuous cs_n low, 2 words, tx 0x11 then 0x22, rx 0x55 then 0xAA, with m_axis_tready held low after the first -> second word 0xAA overwrites; rx_overrun_error=1 until handshake.
- cs_n high after 3 bits, then a new transfer of 0xC3 -> no m_axis word from the aborted transfer; the next word receives 0xC3 correctly; miso_t=1 while cs_n is high.
- Empty tx holding register at cs_n fall -> miso shifts 0x00; tx_underrun_error pulses 1 cycle. Reset asserted mid-word -> all outputs return to reset values within the same cycle.
